// File: rtl/queue_ctrl_if.sv
// Handshake and memory-port bundle for queue_ctrl: producer push, consumer pop, external RAM.
// The controller uses the slave modport; the producer/consumer/memory side uses master.
interface queue_ctrl_if #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [DEPTH_LOG2-1:0] mem_raddr;
    logic [WIDTH-1:0]      mem_rdata;

    modport master (
        output in_valid, in_data, out_ready, mem_rdata,
        input  in_ready, out_valid, out_data, mem_we, mem_waddr, mem_wdata, mem_raddr
    );

    modport slave (
        input  in_valid, in_data, out_ready, mem_rdata,
        output in_ready, out_valid, out_data, mem_we, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/queue_ctrl.sv
// FIFO controller over an external 1-cycle-latency RAM with a 2-entry prefetch buffer.
// Optional QUEUE_CTRL_STATS_EN adds a saturating drop_cnt of refused pushes.
module queue_ctrl #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    queue_ctrl_if.slave       q,
`ifdef QUEUE_CTRL_STATS_EN
    output logic [15:0]       drop_cnt,
`endif
    output logic [DEPTH_LOG2:0] count
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam int PW = DEPTH_LOG2;
    localparam logic [CW-1:0] MEM_FULL = {1'b1, {PW{1'b0}}};

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    mem_count;
    logic             inflight;
    logic [1:0]       buf_count;
    logic [WIDTH-1:0] buf_data [2];

    logic push;
    logic pop;
    logic issue;

    always_comb begin
        q.in_ready  = (mem_count != MEM_FULL);
        q.out_valid = (buf_count != 2'd0);
        q.out_data  = buf_data[0];
        push        = q.in_valid && q.in_ready;
        pop         = q.out_valid && q.out_ready;
        // Buffer slots already claimed (held + arriving) minus the one leaving must stay below 2.
        issue       = (mem_count != '0) &&
                      (({1'b0, buf_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
        q.mem_we    = push;
        q.mem_waddr = wptr;
        q.mem_wdata = q.in_data;
        q.mem_raddr = rptr;
        count       = mem_count + CW'(inflight) + CW'(buf_count);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            mem_count <= '0;
            inflight  <= 1'b0;
            buf_count <= 2'd0;
            buf_data  <= '{default: '0};
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            mem_count <= '0;
            inflight  <= 1'b0;
            buf_count <= 2'd0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (issue)
                rptr <= rptr + PW'(1);
            inflight <= issue;
            if (push && !issue)
                mem_count <= mem_count + CW'(1);
            else if (!push && issue)
                mem_count <= mem_count - CW'(1);

            // Head always lives in slot 0; a pop shifts slot 1 down before the tail write lands.
            case ({pop, inflight})
                2'b10: begin
                    buf_data[0] <= buf_data[1];
                    buf_count   <= buf_count - 2'd1;
                end
                2'b01: begin
                    if (buf_count == 2'd0)
                        buf_data[0] <= q.mem_rdata;
                    else
                        buf_data[1] <= q.mem_rdata;
                    buf_count <= buf_count + 2'd1;
                end
                2'b11: begin
                    if (buf_count == 2'd1) begin
                        buf_data[0] <= q.mem_rdata;
                    end else begin
                        buf_data[0] <= buf_data[1];
                        buf_data[1] <= q.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef QUEUE_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt <= '0;
        else if (flush)
            drop_cnt <= '0;
        else if (q.in_valid && !q.in_ready && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_queue_ctrl.sv
// Self-checking bench for queue_ctrl: vector tables plus scoreboard-checked multi-cycle sequences.
module tb_queue_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [3:0] count;
`ifdef QUEUE_CTRL_STATS_EN
    logic [15:0] drop_cnt;
`endif

    queue_ctrl_if #(.DEPTH_LOG2(3), .WIDTH(8)) q_if ();

    queue_ctrl #(.DEPTH_LOG2(3), .WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .q        (q_if.slave),
`ifdef QUEUE_CTRL_STATS_EN
        .drop_cnt (drop_cnt),
`endif
        .count    (count)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [8];
    always @(posedge clk) begin
        if (q_if.mem_we)
            mem[q_if.mem_waddr] <= q_if.mem_wdata;
        q_if.mem_rdata <= mem[q_if.mem_raddr];
    end

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb [$];
    logic [2:0] wptr_m = '0;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic ordy,
                                input logic fl, input logic e_ir, input logic e_ov,
                                input logic [7:0] e_od, input logic [3:0] e_cnt);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample 2 time units later, scoreboard the handshakes.
    task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy, input logic fl,
                         output logic acc, output logic popped);
        logic [7:0] e;
        @(negedge clk);
        q_if.in_valid  = iv;
        q_if.in_data   = d;
        q_if.out_ready = ordy;
        flush          = fl;
        #2;
        check("count_vs_model", 32'(count), 32'(sb.size()));
        acc    = iv && q_if.in_ready;
        popped = q_if.out_valid && ordy;
        check("mem_we", 32'(q_if.mem_we), 32'(acc));
        if (acc)
            check("mem_waddr", 32'(q_if.mem_waddr), 32'(wptr_m));
        if (popped && !fl) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_underflow: got %0h expected no output", q_if.out_data);
            end else begin
                e = sb.pop_front();
                check("out_data", 32'(q_if.out_data), 32'(e));
            end
        end
        if (fl) begin
            sb.delete();
            wptr_m = '0;
        end else if (acc) begin
            sb.push_back(d);
            wptr_m = wptr_m + 3'd1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        q_if.in_valid  = 1'b0;
        q_if.out_ready = 1'b0;
        flush          = 1'b0;
        rst            = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        wptr_m = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within 200000");
        $fatal(1);
    end

    initial begin
        logic       acc, popped, done;
        logic [7:0] d;
        int         first, last, npop, misses;

        rst            = 1'b1;
        flush          = 1'b0;
        q_if.in_valid  = 1'b0;
        q_if.in_data   = '0;
        q_if.out_ready = 1'b0;

        // single push latency, then flush and recovery
        tbl[0]  = mk(1, 8'hA5, 1, 0, 1, 0, 8'h00, 0);
        tbl[1]  = mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1);
        tbl[2]  = mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1);
        tbl[3]  = mk(0, 8'h00, 1, 0, 1, 1, 8'hA5, 1);
        tbl[4]  = mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
        tbl[5]  = mk(1, 8'h01, 0, 0, 1, 0, 8'h00, 0);
        tbl[6]  = mk(1, 8'h02, 0, 0, 1, 0, 8'h00, 1);
        tbl[7]  = mk(1, 8'h03, 0, 0, 1, 0, 8'h00, 2);
        tbl[8]  = mk(1, 8'h04, 0, 0, 1, 1, 8'h01, 3);
        tbl[9]  = mk(1, 8'h05, 0, 0, 1, 1, 8'h01, 4);
        tbl[10] = mk(0, 8'h00, 0, 1, 1, 1, 8'h01, 5);
        tbl[11] = mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
        tbl[12] = mk(1, 8'h77, 1, 0, 1, 0, 8'h00, 0);
        tbl[13] = mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1);
        tbl[14] = mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 1);
        tbl[15] = mk(0, 8'h00, 1, 0, 1, 1, 8'h77, 1);
        tbl[16] = mk(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("reset_out_valid", 32'(q_if.out_valid), 0);
        check("reset_in_ready", 32'(q_if.in_ready), 1);
        check("reset_count", 32'(count), 0);
        check("reset_mem_we", 32'(q_if.mem_we), 0);

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, acc, popped);
            check($sformatf("vec%0d_in_ready", i), 32'(q_if.in_ready), 32'(tbl[i].e_ir));
            check($sformatf("vec%0d_out_valid", i), 32'(q_if.out_valid), 32'(tbl[i].e_ov));
            check($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            if (tbl[i].e_ov)
                check($sformatf("vec%0d_out_data", i), 32'(q_if.out_data), 32'(tbl[i].e_od));
        end

        // fill with consumer stalled, then drain
        do_reset();
        d = 8'h00;
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, d, 1'b0, 1'b0, acc, popped);
            if (acc) d = d + 8'd1;
        end
        check("fill_accepted", 32'(d), 10);
        cycle(1'b1, d, 1'b0, 1'b0, acc, popped);
        check("full_in_ready", 32'(q_if.in_ready), 0);
        check("full_count", 32'(count), 10);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            cycle(d <= 8'h0A, d, 1'b1, 1'b0, acc, popped);
            if (acc) d = d + 8'd1;
            if (d == 8'h0B && sb.size() == 0) done = 1'b1;
        end
        check("drain_done", 32'(done), 1);

        // continuous streaming, pointers wrap twice
        do_reset();
        d = 8'h10; first = -1; last = -1; npop = 0; misses = 0;
        for (int i = 0; i < 40 && npop < 20; i++) begin
            cycle(d < 8'h24, d, 1'b1, 1'b0, acc, popped);
            if (d < 8'h24 && !acc) misses++;
            if (acc) d = d + 8'd1;
            if (popped) begin
                if (first < 0) first = i;
                last = i;
                npop++;
            end
        end
        check("stream_pops", 32'(npop), 20);
        check("stream_latency", 32'(first), 3);
        check("stream_no_gaps", 32'(last - first), 19);
        check("stream_push_stalls", 32'(misses), 0);

        // async reset mid-stream without a clock edge
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, acc, popped);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 8'h00, 1'b0, 1'b0, acc, popped);
        check("pre_rst_out_valid", 32'(q_if.out_valid), 1);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(q_if.out_valid), 0);
        check("async_rst_count", 32'(count), 0);
        check("async_rst_in_ready", 32'(q_if.in_ready), 1);
        check("async_rst_mem_we", 32'(q_if.mem_we), 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        wptr_m = '0;
        npop = 0;
        cycle(1'b1, 8'h5C, 1'b1, 1'b0, acc, popped);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, acc, popped);
            if (popped) npop++;
        end
        check("post_rst_pops", 32'(npop), 1);

`ifdef QUEUE_CTRL_STATS_EN
        cycle(1'b0, 8'h00, 1'b0, 1'b1, acc, popped);
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, acc, popped);
        check("drop_cnt_before", 32'(drop_cnt), 0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 8'hEE, 1'b0, 1'b0, acc, popped);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, acc, popped);
        check("drop_cnt_after", 32'(drop_cnt), 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/queue_ctrl.md
Name: queue_ctrl

Overview:
Controller that turns the 8-entry, 1-cycle-read-latency byte memory of the JTAG UART path into a FIFO with valid/ready handshakes on both sides. It owns the read/write pointers, occupancy, and write strobe. A 2-entry prefetch buffer hides the memory read latency, so the block sustains one transfer per cycle. It sits between the JTAG byte producer and the UART TX consumer. The memory instance stays external.

Parameters:
DEPTH_LOG2, 3, log2 of memory entries (DEPTH = 2^DEPTH_LOG2); legal range >= 2
WIDTH, 8, data width in bits

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous clear of all queued data
in_valid  in  1  producer has data
in_ready  out  1  controller accepts in_data this cycle
in_data  in  WIDTH  push data
out_valid  out  1  out_data is valid
out_ready  in  1  consumer takes out_data this cycle
out_data  out  WIDTH  head-of-queue data
mem_we  out  1  memory write enable
mem_waddr  out  DEPTH_LOG2  memory write address
mem_wdata  out  WIDTH  memory write data
mem_raddr  out  DEPTH_LOG2  memory read address; rdata appears one cycle later
mem_rdata  in  WIDTH  memory read data
count  out  DEPTH_LOG2+1  total entries held (memory + in-flight + buffer)

Behaviour:
- Reset, asynchronous: wptr=rptr=0, mem_count=0, inflight=0, buffer empty. Outputs: out_valid=0, count=0, mem_we=0, in_ready=1. Memory contents are not cleared.
- Push rule: push = in_valid & in_ready. in_ready = (mem_count < DEPTH), computed from registered state only.
- Write path: mem_we = push, mem_waddr = wptr, mem_wdata = in_data (all combinational). wptr increments on push and wraps DEPTH-1 to 0.
- Read path: mem_raddr = rptr at all times.
- Read issue: issue = (mem_count != 0) & (buf_count + inflight - pop < 2), using registered mem_count.
- On issue: rptr increments with wrap, and inflight is set for the next cycle. When inflight=1, mem_rdata is written into the buffer tail at that clock edge.
- mem_count next = mem_count + push - issue.
- Buffer: 2-entry FIFO of registers. out_valid = (buf_count != 0); out_data = buffer head. pop = out_valid & out_ready.
- Hazard freedom: a read never targets the address being written in the same cycle. Reads issue only when mem_count != 0, and writes only when mem_count < DEPTH. No read-after-write bypass is needed.
- Latency: a push accepted in cycle t gives out_valid=1 in cycle t+3 when the queue was empty.
- Throughput: 1 transfer/cycle in steady state. Data order is strictly FIFO.
- Capacity: DEPTH + 2 entries total. count = mem_count + inflight + buf_count.
- Full, out_ready held low: buffer fills to 2 and issue stops; memory fills to DEPTH; in_ready=0.
- Empty: out_valid=0. out_ready is a don't-care.
- Simultaneous push and pop: both complete; count is unchanged.
- flush, on the next edge: pointers, mem_count, inflight, and buffer all return to 0. A push or pop in the flush cycle is discarded, although mem_we may still pulse. A read in flight is dropped.
- Reset mid-operation: same effect as flush, but asynchronous.

Optional Feature:
QUEUE_CTRL_STATS_EN
- Defined: adds output drop_cnt [15:0]. It increments in every cycle with in_valid & !in_ready, saturates at 0xFFFF, and clears on rst or flush.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset applied and released, idle inputs -> out_valid=0, in_ready=1, count=0, mem_we=0.
- Single push 0xA5 in cycle 0, out_ready=1 -> mem_we=1, mem_waddr=0 in cycle 0; out_valid=1, out_data=0xA5 in cycle 3; count returns to 0 after the pop.
- out_ready=0, push 0x00..0x0A back-to-back -> 10 accepted, in_ready=0 from then on, count=10. Then out_ready=1 -> 0x00..0x09 out in order, and the 0x0A push is accepted once in_ready rises.
- in_valid=1, out_ready=1 continuous, data 0x10..0x23 -> after 3-cycle latency one byte per cycle, in order, no gaps, pointers wrap twice.
- Load 5 entries, assert flush one cycle -> next cycle count=0, out_valid=0. Push 0x77 -> first output is 0x77.
- Async rst pulse mid-stream, no clock edge -> outputs drop to reset values immediately. With QUEUE_CTRL_STATS_EN: holding in_valid for 3 cycles while full gives drop_cnt=3.
